// File: rtl/hpi_txn_sequencer_if.sv
// Request/response handshake plus software-side pin-stage strobes for the HPI sequencer.
interface hpi_txn_sequencer_if;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 16;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] sw_address;
  logic [DATA_W-1:0] sw_data_out;
  logic              sw_cs;
  logic              sw_r;
  logic              sw_w;
  logic [DATA_W-1:0] sw_data_in;

  // Requester and pin stage side.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, sw_data_in,
    input  req_ready, resp_valid, resp_rdata,
    input  sw_address, sw_data_out, sw_cs, sw_r, sw_w
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, sw_data_in,
    output req_ready, resp_valid, resp_rdata,
    output sw_address, sw_data_out, sw_cs, sw_r, sw_w
  );
endinterface

// File: rtl/hpi_txn_sequencer.sv
// Turns single 16-bit HPI read/write requests into timed CY7C67200 software-side strobes
// and returns read data with a one-cycle completion pulse.
module hpi_txn_sequencer #(
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned RECOV_CYC  = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  hpi_txn_sequencer_if.slave bus
);

  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned MAX_CYC = (STROBE_CYC > RECOV_CYC) ? STROBE_CYC : RECOV_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_RECOV  = 3'd4;

  logic [2:0]        state,      state_nx;
  logic [CNT_W-1:0]  cnt,        cnt_nx;
  logic              hold_2nd,   hold_2nd_nx;
  logic              lat_write,  lat_write_nx;
  logic              ready_q,    ready_nx;
  logic              rvalid_q,   rvalid_nx;
  logic [DATA_W-1:0] rdata_q,    rdata_nx;
  logic [ADDR_W-1:0] addr_q,     addr_nx;
  logic [DATA_W-1:0] dout_q,     dout_nx;
  logic              cs_q,       cs_nx;
  logic              rd_q,       rd_nx;
  logic              wr_q,       wr_nx;

  // State and every output are registered so the strobes cannot glitch.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hold_2nd  <= 1'b0;
      lat_write <= 1'b0;
      ready_q   <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      cs_q      <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      hold_2nd  <= hold_2nd_nx;
      lat_write <= lat_write_nx;
      ready_q   <= ready_nx;
      rvalid_q  <= rvalid_nx;
      rdata_q   <= rdata_nx;
      addr_q    <= addr_nx;
      dout_q    <= dout_nx;
      cs_q      <= cs_nx;
      rd_q      <= rd_nx;
      wr_q      <= wr_nx;
    end
  end

  // Next state plus the output values that must be visible during that next state.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    hold_2nd_nx  = hold_2nd;
    lat_write_nx = lat_write;
    ready_nx     = 1'b0;
    rvalid_nx    = 1'b0;
    rdata_nx     = rdata_q;
    addr_nx      = addr_q;
    dout_nx      = dout_q;
    cs_nx        = 1'b1;
    rd_nx        = 1'b1;
    wr_nx        = 1'b1;

    case (state)
      ST_IDLE: begin
        ready_nx = 1'b1;
        if (bus.req_valid && ready_q) begin
          state_nx     = ST_SETUP;
          lat_write_nx = bus.req_write;
          addr_nx      = bus.req_addr;
          dout_nx      = bus.req_wdata;
          ready_nx     = 1'b0;
          cs_nx        = 1'b0;
        end
      end

      ST_SETUP: begin
        state_nx = ST_STROBE;
        cnt_nx   = CNT_W'(STROBE_CYC);
        cs_nx    = 1'b0;
        rd_nx    = lat_write;
        wr_nx    = ~lat_write;
      end

      ST_STROBE: begin
        cs_nx = 1'b0;
        if (cnt == CNT_W'(1)) begin
          state_nx    = ST_HOLD;
          cnt_nx      = '0;
          hold_2nd_nx = 1'b0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
          rd_nx  = lat_write;
          wr_nx  = ~lat_write;
        end
      end

      // Two cycles cover the strobe going out through the pin stage and the data coming back.
      ST_HOLD: begin
        cs_nx = 1'b0;
        if (!hold_2nd) begin
          hold_2nd_nx = 1'b1;
        end else begin
          hold_2nd_nx = 1'b0;
          state_nx    = ST_RECOV;
          cnt_nx      = CNT_W'(RECOV_CYC);
          rvalid_nx   = 1'b1;
          cs_nx       = 1'b1;
          if (!lat_write) begin
            rdata_nx = bus.sw_data_in;
          end
        end
      end

      ST_RECOV: begin
        if (cnt == CNT_W'(1)) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
          ready_nx = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end

      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
        ready_nx = 1'b1;
      end
    endcase
  end

  assign bus.req_ready   = ready_q;
  assign bus.resp_valid  = rvalid_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.sw_address  = addr_q;
  assign bus.sw_data_out = dout_q;
  assign bus.sw_cs       = cs_q;
  assign bus.sw_r        = rd_q;
  assign bus.sw_w        = wr_q;

endmodule

// File: doc/hpi_txn_sequencer.md
# hpi_txn_sequencer

Hardware transaction sequencer for the CY7C67200 host-port interface (HPI). It accepts single 16-bit read/write requests over a valid/ready handshake and generates the correctly timed software-side strobes (address, chip-select, read, write, write data) consumed by the HPI pin-interface stage. It captures the returned read data and reports completion with a one-cycle response pulse. It sits directly upstream of the pin-interface stage and lets logic other than the NIOS processor access the USB controller's HPI registers.

## Interface
- STROBE_CYC, 4, cycles the read/write strobe is held low (legal range ≥1; 4 = 80 ns at 50 MHz)
- RECOV_CYC, 2, cycles chip-select is held high after a transaction before the next is accepted (≥1)
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer occurs on a cycle where req_valid & req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  2  HPI address (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS)
- req_wdata  in  16  write data
- resp_valid  out  1  one-cycle completion pulse, for both reads and writes
- resp_rdata  out  16  read data; valid when resp_valid is high after a read and held until the next read completes
- sw_address  out  2  to pin stage, address
- sw_data_out  out  16  to pin stage, write data
- sw_cs, sw_r, sw_w  out  1 each  to pin stage, active-low chip-select, read and write
- sw_data_in  in  16  from pin stage, registered pin data

## Operation
- All outputs are registered; strobes never glitch.
- States: IDLE, SETUP, STROBE, HOLD, RECOV.
- IDLE:
  - req_ready=1, sw_cs=sw_r=sw_w=1.
  - On handshake, latch req_write, req_addr and req_wdata, then go to SETUP.
  - Request inputs are ignored after the handshake.
- SETUP (1 cycle):
  - sw_cs=0, sw_address and sw_data_out driven from the latched values, sw_r=sw_w=1.
- STROBE (STROBE_CYC cycles):
  - sw_cs=0; sw_r=0 for a read, or sw_w=0 for a write.
  - sw_r and sw_w are never low together.
  - Write data is driven only while sw_w is low, because the pin stage tristates the bus when sw_w is high.
- HOLD (2 cycles):
  - sw_cs=0, sw_r=sw_w=1, address and data unchanged.
  - This covers the 2-cycle round trip through the pin stage: strobe out and data back.
  - For a read, resp_rdata is loaded from sw_data_in at the clock edge ending the second HOLD cycle. That value is pin data sampled while OTG_RD_N was low.
- RECOV (RECOV_CYC cycles):
  - sw_cs=1.
  - resp_valid=1 in the first RECOV cycle only.
  - Go to IDLE after the last RECOV cycle.
- A down-counter sized for max(STROBE_CYC, RECOV_CYC) times STROBE and RECOV. Loading it with N gives exactly N cycles.
- req_valid while not in IDLE: no effect, no queueing.
- sw_address and sw_data_out keep their last values in IDLE and RECOV.

## Timing
- Cycle 0 is the handshake cycle (IDLE with req_valid=1).
- Phase schedule:
  - SETUP: cycle 1
  - STROBE: cycles 2..STROBE_CYC+1
  - HOLD: STROBE_CYC+2 and STROBE_CYC+3
  - resp_valid: cycle STROBE_CYC+4
  - req_ready high again: cycle STROBE_CYC+4+RECOV_CYC
- With defaults: strobe cycles 2-5, resp_valid at cycle 8, next handshake possible at cycle 10. Back-to-back throughput is 1 transaction per 10 cycles.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, sw_cs=sw_r=sw_w=1, sw_address=0, sw_data_out=0, counter 0.
- Reset mid-transaction (any state):
  - Strobes and sw_cs go high immediately, without waiting for a clock edge.
  - No resp_valid is issued for the aborted request.
  - resp_rdata returns to 0.
- req_valid held high continuously: one request is accepted per IDLE visit, with exactly the spacing above.

## Test plan
- Reset released, write req_addr=2, req_wdata=0x051C -> sw_cs low cycles 1-7, sw_w low cycles 2-5 with sw_data_out=0x051C and sw_address=2, sw_r high throughout, resp_valid only at cycle 8, req_ready=1 at cycle 10.
- Read req_addr=0 with the bench modelling the pin stage (2-cycle round trip) returning 0xBEEF while RD low -> resp_rdata=0xBEEF at cycle 8; sw_w never low.
- Write 0x1234 immediately followed by a read (req_valid held high) -> second handshake exactly at cycle 10, strobe intervals non-overlapping, sw_cs high during cycles 8-9.
- req_valid pulsed with req_wdata changing every cycle during cycles 1-9 -> no extra handshake, and sw_data_out stays at the value latched at cycle 0.
- Reset asserted asynchronously mid-STROBE (cycle 3) of a read -> sw_r and sw_cs high before the next edge, no resp_valid, resp_rdata=0, req_ready=1 after release.
- STROBE_CYC=1, RECOV_CYC=1 -> strobe low exactly 1 cycle (cycle 2), resp_valid at cycle 5, next handshake at cycle 6.
